// File: rtl/platform_pkg.sv
// Tower platform geometry shared by the renderer and the collision scanner,
// so drawing and collision always agree on where platforms are.
package platform_pkg;

  localparam int SCREEN_WIDTH    = 1024;
  localparam int SCREEN_HEIGHT   = 768;
  localparam int PLATFORM_WIDTH  = 512;
  localparam int PLATFORM_HEIGHT = 10;
  localparam int N_PLATFORMS     = 10;
  localparam int SCALE           = 2;
  localparam int CHAR_W          = 32;
  localparam int CHAR_H          = 48;

  localparam int S_W = PLATFORM_WIDTH * SCALE;
  localparam int S_H = PLATFORM_HEIGHT * SCALE;
  localparam int X0  = (SCREEN_WIDTH - S_W) / 2;
  localparam int X1  = X0 + S_W - 1;
  localparam int GAP = (SCREEN_HEIGHT - N_PLATFORMS * S_H) / (N_PLATFORMS - 1);

  // Platform 0 sits on the bottom edge; higher indices stack upwards.
  function automatic int plat_y_start(int i);
    return SCREEN_HEIGHT - S_H - i * (S_H + GAP);
  endfunction

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

endpackage

// File: rtl/platform_collision.sv
// Per-frame scan of all platforms against the character box; reports the
// first landing platform (with snapped Y) and the first head-bump platform.
module platform_collision
  import platform_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [10:0] char_x_i,
  input  logic [10:0] char_y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        on_platform_o,
  output logic [3:0]  plat_idx_o,
  output logic [10:0] land_y_o,
  output logic        head_hit_o,
  output logic [3:0]  head_idx_o
);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [10:0] cx_q, cy_q;
  logic        busy_q, done_q, on_q, head_q;
  logic [3:0]  pidx_q, hidx_q;
  logic [10:0] land_q;

  int          ys, ye, right, feet;
  logic        overlap, land_match, head_match;
  logic [10:0] snap_y;

  always_comb begin
    ys         = plat_y_start(int'(idx_q));
    ye         = ys + S_H - 1;
    right      = int'(cx_q) + CHAR_W - 1;
    feet       = int'(cy_q) + CHAR_H;
    overlap    = (right >= X0) && (int'(cx_q) <= X1);
    land_match = overlap && (feet >= ys) && (feet <= ye);
    head_match = overlap && (int'(cy_q) >= ys) && (int'(cy_q) <= ye);
    // Clamp so the top platform never snaps the character above row 0.
    snap_y     = (ys - CHAR_H < 0) ? 11'd0 : 11'(ys - CHAR_H);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
      pidx_q  <= '0;
      land_q  <= '0;
      head_q  <= 1'b0;
      hidx_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          busy_q <= req_i;
          if (req_i) begin
            cx_q    <= char_x_i;
            cy_q    <= char_y_i;
            idx_q   <= '0;
            on_q    <= 1'b0;
            pidx_q  <= '0;
            land_q  <= '0;
            head_q  <= 1'b0;
            hidx_q  <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          busy_q <= 1'b1;
          if (land_match && !on_q) begin
            on_q   <= 1'b1;
            pidx_q <= idx_q;
            land_q <= snap_y;
          end
          if (head_match && !head_q) begin
            head_q <= 1'b1;
            hidx_q <= idx_q;
          end
          if (idx_q == 4'(N_PLATFORMS - 1)) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        StDone: begin
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign on_platform_o = on_q;
  assign plat_idx_o    = pidx_q;
  assign land_y_o      = land_q;
  assign head_hit_o    = head_q;
  assign head_idx_o    = hidx_q;

endmodule

// File: tb/tb_platform_collision.sv
// Directed bench for platform_collision: a timeline/geometry model checked
// every cycle, plus literal expectations per scenario.
module tb_platform_collision;

  localparam int NP   = 10;
  localparam int SH   = 2 * 10;
  localparam int GAPM = (768 - NP * SH) / (NP - 1);
  localparam int LAT  = NP + 1;

  logic        clk = 1'b0;
  logic        rst, req;
  logic [10:0] cx, cy;
  logic        busy, done, on_p, head;
  logic [3:0]  pidx, hidx;
  logic [10:0] land;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  bit m_active;
  int m_cnt;
  bit m_on, m_head, p_on, p_head;
  int m_pidx, m_land, m_hidx, p_pidx, p_land, p_hidx;

  platform_collision dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .char_x_i     (cx),
    .char_y_i     (cy),
    .busy_o       (busy),
    .done_o       (done),
    .on_platform_o(on_p),
    .plat_idx_o   (pidx),
    .land_y_o     (land),
    .head_hit_o   (head),
    .head_idx_o   (hidx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Geometry straight from the platform layout: first hit in ascending index wins.
  task automatic model_scan(input int x, input int y);
    int top, bot, feet;
    bit ovl;
    p_on = 0; p_head = 0; p_pidx = 0; p_land = 0; p_hidx = 0;
    ovl  = (x + 32 - 1 >= 0) && (x <= 1023);
    feet = y + 48;
    for (int i = 0; i < NP; i++) begin
      top = 768 - SH - i * (SH + GAPM);
      bot = top + SH - 1;
      if (ovl && !p_on && feet >= top && feet <= bot) begin
        p_on = 1; p_pidx = i; p_land = (top - 48 < 0) ? 0 : top - 48;
      end
      if (ovl && !p_head && y >= top && y <= bot) begin
        p_head = 1; p_hidx = i;
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_cnt = 0;
      m_on = 0; m_head = 0; m_pidx = 0; m_land = 0; m_hidx = 0;
    end else if ((!m_active || m_cnt == LAT) && req) begin
      m_active = 1; m_cnt = 0;
      m_on = 0; m_head = 0; m_pidx = 0; m_land = 0; m_hidx = 0;
      model_scan(int'(cx), int'(cy));
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == LAT) begin
        m_on = p_on; m_pidx = p_pidx; m_land = p_land; m_head = p_head; m_hidx = p_hidx;
      end else if (m_cnt > LAT) begin
        m_active = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", int'(busy), int'(m_active && m_cnt <= LAT));
      chk("done", int'(done), int'(m_active && m_cnt == LAT));
      if (!(m_active && m_cnt < LAT)) begin
        chk("on_platform", int'(on_p), int'(m_on));
        chk("plat_idx", int'(pidx), m_pidx);
        chk("land_y", int'(land), m_land);
        chk("head_hit", int'(head), int'(m_head));
        chk("head_idx", int'(hidx), m_hidx);
      end
    end
  end

  // Pulse req for one cycle; returns with the request accepted at the last edge.
  task automatic issue(input int x, input int y);
    @(posedge clk); #1;
    req = 1'b1; cx = 11'(x); cy = 11'(y);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_edges);
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, exp_edges);
  endtask

  task automatic run(input string name, input int x, input int y, input int e_on,
                     input int e_pidx, input int e_land, input int e_head, input int e_hidx);
    issue(x, y);
    wait_done({name, "_latency"}, LAT);
    chk({name, "_on"}, int'(on_p), e_on);
    chk({name, "_pidx"}, int'(pidx), e_pidx);
    chk({name, "_land"}, int'(land), e_land);
    chk({name, "_head"}, int'(head), e_head);
    chk({name, "_hidx"}, int'(hidx), e_hidx);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b1; req = 1'b0; cx = '0; cy = '0;
    @(posedge clk); #1;
    started = 1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_on", int'(on_p), 0);
    chk("reset_land", int'(land), 0);

    run("t1_stand", 100, 700, 1, 0, 700, 0, 0);
    run("t2_lastrow", 100, 719, 1, 0, 700, 0, 0);
    run("t3_gap_head", 100, 600, 0, 0, 0, 1, 2);
    run("t4_offscreen", 1030, 700, 0, 0, 0, 0, 0);
    run("t_xedge_in", 1023, 700, 1, 0, 700, 0, 0);
    run("t_xedge_out", 1024, 700, 0, 0, 0, 0, 0);
    run("t_high_plat", 300, 40, 1, 8, 36, 0, 0);
    run("t_top_head", 300, 10, 0, 0, 0, 1, 9);

    // Request during scan must be dropped.
    issue(100, 700);
    repeat (2) @(posedge clk); #1;
    req = 1'b1; cy = 11'd617;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done("t5_ign_latency", LAT - 3);
    chk("t5_ign_pidx", int'(pidx), 0);
    chk("t5_ign_land", int'(land), 700);
    repeat (2) @(posedge clk);
    run("t5_fresh", 100, 617, 1, 1, 617, 0, 0);

    // Held req restarts right after each done; the model tracks the timeline.
    @(posedge clk); #1;
    req = 1'b1; cx = 11'd100; cy = 11'd719;
    repeat (30) @(posedge clk); #1;
    req = 1'b0;
    repeat (16) @(posedge clk); #1;
    chk("held_idle", int'(busy), 0);

    // Reset mid-scan aborts with no done pulse.
    issue(100, 700);
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_on", int'(on_p), 0);
    chk("t6_land", int'(land), 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("t6_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
